// File: rtl/usb_acia_fifo.sv
// ACIA-style CPU register interface with RX/TX FIFOs in front of the MUACM USB CDC byte stream.
// Define USB_ACIA_FIFO_LEVEL_EN to make addr 2/3 reads return the RX/TX FIFO occupancy.
module usb_acia_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RX_THRESH  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] rx_data,
  input  logic       rx_val,
  output logic       rx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_val,
  input  logic       tx_rdy,
  output logic       irq
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(RX_THRESH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] rx_count, tx_count;

  logic       rx_ie;
  logic [1:0] tx_mode;
  logic       tx_ovr;

  logic cpu_wr, cpu_rd, flush, status_rd;
  logic rx_push, rx_pop, tx_push, tx_pop, tx_wr, tx_drop;
  logic rx_thr;
  logic [7:0] status;

  assign cpu_wr    = cs & we;
  assign cpu_rd    = cs & ~we;
  assign flush     = cpu_wr && (addr == 2'd0) && (din[1:0] == 2'b11);
  assign status_rd = cpu_rd && (addr == 2'd0);

  assign rx_rdy  = (rx_count != FULL);
  assign rx_push = rx_val & rx_rdy;
  assign rx_pop  = cpu_rd && (addr == 2'd1) && (rx_count != '0);

  assign tx_val  = (tx_count != '0);
  assign tx_data = tx_mem[tx_rd_ptr];
  assign tx_pop  = tx_val & tx_rdy;
  assign tx_wr   = cpu_wr && (addr == 2'd1);
  // A full TX FIFO still takes the byte when the USB side frees the head slot this cycle
  assign tx_push = tx_wr && ((tx_count != FULL) || tx_pop);
  assign tx_drop = tx_wr && !tx_push;

  assign rx_thr = (rx_count >= THRESH);
  assign irq = (rx_ie && rx_thr) ||
               ((tx_mode == 2'b01) && (tx_count != FULL)) ||
               ((tx_mode == 2'b10) && (tx_count == '0)) ||
               tx_ovr;

  assign status = {irq, 1'b0, tx_ovr, rx_thr, 1'b0,
                   (tx_count == '0), (tx_count != FULL), (rx_count != '0)};

`ifdef USB_ACIA_FIFO_LEVEL_EN
  function automatic logic [7:0] level8(input logic [CW-1:0] cnt);
    logic [8:0] wide;
    wide = 9'(cnt);
    return wide[8] ? 8'hFF : wide[7:0];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= din;
  end

  // Flush shares the reset path so it wins over any push or pop in the same cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ie   <= 1'b0;
      tx_mode <= 2'b00;
    end else if (cpu_wr && (addr == 2'd0)) begin
      rx_ie   <= din[7];
      tx_mode <= din[6:5];
    end
  end

  // An overrun in the same cycle as a status read keeps the flag set
  always_ff @(posedge clk) begin
    if (rst || flush)   tx_ovr <= 1'b0;
    else if (tx_drop)   tx_ovr <= 1'b1;
    else if (status_rd) tx_ovr <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 8'h00;
    end else if (cpu_rd) begin
      case (addr)
        2'd0: dout <= status;
        2'd1: dout <= rx_pop ? rx_mem[rx_rd_ptr] : 8'h00;
`ifdef USB_ACIA_FIFO_LEVEL_EN
        2'd2: dout <= level8(rx_count);
        default: dout <= level8(tx_count);
`else
        default: dout <= 8'h00;
`endif
      endcase
    end
  end

endmodule

// File: tb/tb_usb_acia_fifo.sv
// Self-checking bench for usb_acia_fifo: queue-based reference model checked every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_usb_acia_fifo;

  localparam int DEPTH_LOG2 = 2;
  localparam int RX_THRESH  = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0, we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] rx_data = 8'h00;
  logic       rx_val = 1'b0;
  logic       rx_rdy;
  logic [7:0] tx_data;
  logic       tx_val;
  logic       tx_rdy = 1'b0;
  logic       irq;

  // Persistent USB-side stimulus, applied on every bench cycle
  logic       r_val = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       t_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  usb_acia_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .RX_THRESH(RX_THRESH)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .rx_data(rx_data), .rx_val(rx_val), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_val(tx_val), .tx_rdy(tx_rdy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: byte queues plus the architectural registers
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] m_dout = 8'h00;
  logic [7:0] m_ctrl = 8'h00;
  logic       m_ovr = 1'b0;
  logic       model_ok = 1'b0;

  function automatic logic model_irq();
    return (m_ctrl[7] && rx_q.size() >= RX_THRESH) ||
           (m_ctrl[6:5] == 2'b01 && tx_q.size() != DEPTH) ||
           (m_ctrl[6:5] == 2'b10 && tx_q.size() == 0) ||
           m_ovr;
  endfunction

  function automatic logic [7:0] model_status();
    return {model_irq(), 1'b0, m_ovr, (rx_q.size() >= RX_THRESH), 1'b0,
            (tx_q.size() == 0), (tx_q.size() != DEPTH), (rx_q.size() != 0)};
  endfunction

  function automatic logic [7:0] model_level(input int n);
`ifdef USB_ACIA_FIFO_LEVEL_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n >= 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  always @(posedge clk) begin : model
    int   rxn, txn;
    logic usb_pop, usb_push, ovr_next;
    if (rst) begin
      rx_q.delete();
      tx_q.delete();
      m_dout = 8'h00;
      m_ctrl = 8'h00;
      m_ovr = 1'b0;
      model_ok = 1'b1;
    end else begin
      rxn = rx_q.size();
      txn = tx_q.size();
      usb_pop = (txn != 0) && tx_rdy;
      usb_push = rx_val && (rxn != DEPTH);
      ovr_next = m_ovr;
      if (cs && !we) begin
        case (addr)
          2'd0: begin m_dout = model_status(); ovr_next = 1'b0; end
          2'd1: m_dout = (rxn != 0) ? rx_q.pop_front() : 8'h00;
          2'd2: m_dout = model_level(rxn);
          default: m_dout = model_level(txn);
        endcase
      end
      if (usb_pop) void'(tx_q.pop_front());
      if (usb_push) rx_q.push_back(rx_data);
      if (cs && we && addr == 2'd1) begin
        if (txn < DEPTH || usb_pop) tx_q.push_back(din);
        else ovr_next = 1'b1;
      end
      if (cs && we && addr == 2'd0) begin
        m_ctrl = din;
        if (din[1:0] == 2'b11) begin
          rx_q.delete();
          tx_q.delete();
          ovr_next = 1'b0;
        end
      end
      m_ovr = ovr_next;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("model_rx_rdy", {7'b0, rx_rdy}, {7'b0, rx_q.size() != DEPTH});
      checkOutput("model_tx_val", {7'b0, tx_val}, {7'b0, tx_q.size() != 0});
      checkOutput("model_irq", {7'b0, irq}, {7'b0, model_irq()});
      checkOutput("model_dout", dout, m_dout);
      if (tx_q.size() != 0) checkOutput("model_tx_data", tx_data, tx_q[0]);
    end
  end

  task automatic applyStimulus(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d);
    cs = c;
    we = w;
    addr = a;
    din = d;
    rx_val = r_val;
    rx_data = r_data;
    tx_rdy = t_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic cpuWrite(input logic [1:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
  endtask

  task automatic cpuRead(input logic [1:0] a);
    applyStimulus(1'b1, 1'b0, a, 8'h00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_b;
    idle();
    idle();
    rst = 1'b0;

    // Reset state
    cpuRead(2'd0);
    checkOutput("reset_status", dout, 8'h06);
    checkOutput("reset_rx_rdy", {7'b0, rx_rdy}, 8'h01);
    checkOutput("reset_tx_val", {7'b0, tx_val}, 8'h00);
    checkOutput("reset_irq", {7'b0, irq}, 8'h00);

    // TX overrun with USB stalled, then drain in order
    t_rdy = 1'b0;
    for (int i = 0; i < 5; i++) cpuWrite(2'd1, 8'h41 + 8'(i));
    checkOutput("ovr_irq", {7'b0, irq}, 8'h01);
    t_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h41 + 8'(i);
      checkOutput("drain_tx_val", {7'b0, tx_val}, 8'h01);
      checkOutput("drain_tx_data", tx_data, exp_b);
      idle();
    end
    checkOutput("drained_tx_val", {7'b0, tx_val}, 8'h00);
    cpuRead(2'd0);
    checkOutput("ovr_status", dout, 8'hA6);
    cpuRead(2'd0);
    checkOutput("ovr_cleared_status", dout, 8'h06);

    // RX threshold interrupt and CPU data reads
    cpuWrite(2'd0, 8'h80);
    r_val = 1'b1;
    r_data = 8'h10; idle();
    checkOutput("rx1_irq", {7'b0, irq}, 8'h00);
    r_data = 8'h20; idle();
    checkOutput("rx2_irq", {7'b0, irq}, 8'h01);
    r_data = 8'h30; idle();
    r_val = 1'b0;
    cpuRead(2'd1);
    checkOutput("rd1_data", dout, 8'h10);
    checkOutput("rd1_irq", {7'b0, irq}, 8'h01);
    cpuRead(2'd1);
    checkOutput("rd2_data", dout, 8'h20);
    checkOutput("rd2_irq", {7'b0, irq}, 8'h00);
    cpuRead(2'd1);
    checkOutput("rd3_data", dout, 8'h30);
    cpuRead(2'd1);
    checkOutput("rd_empty_data", dout, 8'h00);

    // RX full across pointer wrap, simultaneous read and push
    r_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_data = 8'hA1 + 8'(i);
      idle();
    end
    checkOutput("rx_full_rdy", {7'b0, rx_rdy}, 8'h00);
    r_data = 8'hA5;
    cpuRead(2'd1);
    checkOutput("wrap_rd1", dout, 8'hA1);
    checkOutput("wrap_rdy_back", {7'b0, rx_rdy}, 8'h01);
    cpuRead(2'd1);
    checkOutput("wrap_rd2", dout, 8'hA2);
    r_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_b = 8'hA3 + 8'(i);
      cpuRead(2'd1);
      checkOutput("wrap_rd_tail", dout, exp_b);
    end

    // TX interrupt modes
    cpuWrite(2'd0, 8'h20);
    checkOutput("mode01_irq", {7'b0, irq}, 8'h01);
    cpuWrite(2'd0, 8'h40);
    checkOutput("mode10_irq", {7'b0, irq}, 8'h01);
    t_rdy = 1'b0;
    cpuWrite(2'd1, 8'h55);
    checkOutput("mode10_busy_irq", {7'b0, irq}, 8'h00);
    t_rdy = 1'b1;
    idle();
    cpuWrite(2'd0, 8'h00);

    // Soft flush beats a concurrent USB push
    t_rdy = 1'b0;
    r_val = 1'b1;
    r_data = 8'h77;
    for (int i = 1; i <= 3; i++) cpuWrite(2'd1, 8'(i));
    checkOutput("pre_flush_tx_val", {7'b0, tx_val}, 8'h01);
    r_data = 8'h88;
    cpuWrite(2'd0, 8'h03);
    r_val = 1'b0;
    checkOutput("flush_tx_val", {7'b0, tx_val}, 8'h00);
    checkOutput("flush_rx_rdy", {7'b0, rx_rdy}, 8'h01);
    cpuRead(2'd0);
    checkOutput("flush_status", dout, 8'h06);
    cpuRead(2'd1);
    checkOutput("flush_rx_empty", dout, 8'h00);

    // Level registers
    cpuWrite(2'd0, 8'h00);
    r_val = 1'b1;
    r_data = 8'hB1; cpuWrite(2'd1, 8'hC1);
    r_data = 8'hB2; cpuWrite(2'd1, 8'hC2);
    r_data = 8'hB3; idle();
    r_val = 1'b0;
    cpuRead(2'd2);
`ifdef USB_ACIA_FIFO_LEVEL_EN
    checkOutput("rx_level", dout, 8'h03);
`else
    checkOutput("rx_level", dout, 8'h00);
`endif
    cpuRead(2'd3);
`ifdef USB_ACIA_FIFO_LEVEL_EN
    checkOutput("tx_level", dout, 8'h02);
`else
    checkOutput("tx_level", dout, 8'h00);
`endif

    // Reset mid-transfer
    t_rdy = 1'b1;
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("midrst_tx_val", {7'b0, tx_val}, 8'h00);
    checkOutput("midrst_rx_rdy", {7'b0, rx_rdy}, 8'h01);
    checkOutput("midrst_dout", dout, 8'h00);
    cpuRead(2'd0);
    checkOutput("midrst_status", dout, 8'h06);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
